// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder for one multiplier bit-triplet, with a PIPE_STAGES-deep output pipeline.
// Define BOOTH_ENC_ZERO_FLAG_EN to add the zero-digit flag output Z.
module booth_encoder #(
  parameter int PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  output logic out_valid,
  output logic P0,
  output logic P1,
  output logic P2
`ifdef BOOTH_ENC_ZERO_FLAG_EN
  ,
  output logic Z
`endif
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
    $error("booth_encoder: PIPE_STAGES must be in 1..4");
  end

  typedef struct packed {
`ifdef BOOTH_ENC_ZERO_FLAG_EN
    logic zero;
`endif
    logic neg;
    logic two;
    logic one;
  } enc_t;

  enc_t enc_d;

  always_comb begin
    enc_d      = '0;
    enc_d.one  = B1 ^ B0;
    enc_d.two  = (B2 & ~B1 & ~B0) | (~B2 & B1 & B0);
    enc_d.neg  = B2 & ~(B1 & B0);
`ifdef BOOTH_ENC_ZERO_FLAG_EN
    enc_d.zero = (B2 & B1 & B0) | ~(B2 | B1 | B0);
`endif
  end

  enc_t stg_data  [PIPE_STAGES];
  logic stg_valid [PIPE_STAGES];

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    enc_t d_in;
    logic v_in;

    if (s == 0) begin : g_first
      assign d_in = enc_d;
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = stg_data[s-1];
      assign v_in = stg_valid[s-1];
    end

    // NOTE: data registers get an explicit reset value too, because the outputs
    // must read as a zero digit the instant rst rises, not one edge later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_valid[s] <= 1'b0;
        stg_data[s]  <= '0;
`ifdef BOOTH_ENC_ZERO_FLAG_EN
        stg_data[s].zero <= 1'b1;
`endif
      end else begin
        stg_valid[s] <= v_in;
        // Load only qualified data so idle-cycle X on the triplet never reaches P*.
        if (v_in) begin
          stg_data[s] <= d_in;
        end
      end
    end
  end

  assign out_valid = stg_valid[PIPE_STAGES-1];
  assign P0        = stg_data[PIPE_STAGES-1].one;
  assign P1        = stg_data[PIPE_STAGES-1].two;
  assign P2        = stg_data[PIPE_STAGES-1].neg;
`ifdef BOOTH_ENC_ZERO_FLAG_EN
  assign Z         = stg_data[PIPE_STAGES-1].zero;
`endif

endmodule

// File: tb/tb_booth_encoder.sv
// Scoreboard bench for booth_encoder: PIPE_STAGES=1 and 4 instances share one stimulus stream.
// Checks Z as well when BOOTH_ENC_ZERO_FLAG_EN is defined.
module tb_booth_encoder;

`ifdef BOOTH_ENC_ZERO_FLAG_EN
  localparam bit ZF_EN = 1'b1;
`else
  localparam bit ZF_EN = 1'b0;
`endif
  localparam int LAT [2] = '{1, 4};

  typedef struct {
    int         edge_no;
    logic [3:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic B0 = 1'b0, B1 = 1'b0, B2 = 1'b0;

  logic [2:0] p_1, p_4;
  logic       z_1, z_4;
  logic       ov   [2];
  logic [3:0] po   [2];
  logic [3:0] hold [2];
  exp_t       sb   [2][$];

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  booth_encoder #(.PIPE_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .B0(B0), .B1(B1), .B2(B2),
    .out_valid(ov[0]), .P0(p_1[0]), .P1(p_1[1]), .P2(p_1[2])
`ifdef BOOTH_ENC_ZERO_FLAG_EN
    , .Z(z_1)
`endif
  );

  booth_encoder #(.PIPE_STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .B0(B0), .B1(B1), .B2(B2),
    .out_valid(ov[1]), .P0(p_4[0]), .P1(p_4[1]), .P2(p_4[2])
`ifdef BOOTH_ENC_ZERO_FLAG_EN
    , .Z(z_4)
`endif
  );

`ifndef BOOTH_ENC_ZERO_FLAG_EN
  assign z_1 = 1'b0;
  assign z_4 = 1'b0;
`endif

  assign po[0] = {z_1, p_1};
  assign po[1] = {z_4, p_4};

  // Expected {Z,P2,P1,P0} straight from the digit table.
  function automatic logic [3:0] enc_ref(input logic [2:0] b);
    logic [2:0] p;
    case (b)
      3'b000:  p = 3'b000;
      3'b001:  p = 3'b001;
      3'b010:  p = 3'b001;
      3'b011:  p = 3'b010;
      3'b100:  p = 3'b110;
      3'b101:  p = 3'b101;
      3'b110:  p = 3'b101;
      default: p = 3'b000;
    endcase
    return {ZF_EN & ((b == 3'b000) | (b == 3'b111)), p};
  endfunction

  function automatic logic [3:0] rst_val();
    return {ZF_EN, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] b);
    @(negedge clk);
    in_valid     = v;
    {B2, B1, B0} = b;
  endtask

  // Assert rst between edges and check the outputs clear without a clock edge.
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d rst_valid", LAT[d]), {7'd0, ov[d]}, 8'd0);
      check($sformatf("L%0d rst_data", LAT[d]), {4'd0, po[d]}, {4'd0, rst_val()});
      sb[d].delete();
      hold[d] = rst_val();
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst && in_valid === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        sb[d].push_back('{edge_cnt, enc_ref({B2, B1, B0})});
      end
    end
  end

  // Every idle cycle the outputs must hold the last valid encoding.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (sb[d].size() > 0 && sb[d][0].edge_no + LAT[d] - 1 == edge_cnt) begin
          exp_t e;
          e = sb[d].pop_front();
          check($sformatf("L%0d valid", LAT[d]), {7'd0, ov[d]}, 8'd1);
          check($sformatf("L%0d data", LAT[d]), {4'd0, po[d]}, {4'd0, e.val});
          hold[d] = e.val;
        end else begin
          check($sformatf("L%0d idle_valid", LAT[d]), {7'd0, ov[d]}, 8'd0);
          check($sformatf("L%0d hold", LAT[d]), {4'd0, po[d]}, {4'd0, hold[d]});
        end
      end
    end
  end

  initial begin
    hold[0] = rst_val();
    hold[1] = rst_val();
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d init_valid", LAT[d]), {7'd0, ov[d]}, 8'd0);
      check($sformatf("L%0d init_data", LAT[d]), {4'd0, po[d]}, {4'd0, rst_val()});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) drive(1'b0, 3'b000);

    for (int b = 0; b < 8; b++) drive(1'b1, 3'(b));
    repeat (5) drive(1'b0, 3'b000);

    drive(1'b1, 3'b100);
    repeat (3) drive(1'b0, 3'b111);
    in_valid = 1'b0;
    {B2, B1, B0} = 3'bxxx;
    repeat (4) @(negedge clk);

    drive(1'b1, 3'b101);
    drive(1'b1, 3'b011);
    drive(1'b1, 3'b111);
    repeat (5) drive(1'b0, 3'b000);

    drive(1'b1, 3'b001);
    drive(1'b1, 3'b010);
    drive(1'b1, 3'b011);
    pulse_reset();
    drive(1'b1, 3'b011);
    repeat (5) drive(1'b0, 3'b000);

    for (int i = 0; i < 60; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom));
    end
    repeat (6) drive(1'b0, 3'b000);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d drain", LAT[d]), 8'(sb[d].size()), 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
